// File: rtl/lsu_ctrl_pkg.sv
// Shared types, constants and decode helpers for the load/store unit.
package lsu_ctrl_pkg;

    typedef enum logic [3:0] {
        LSU_NOP = 4'd0,
        LSU_LB  = 4'd1,
        LSU_LH  = 4'd2,
        LSU_LW  = 4'd3,
        LSU_LBU = 4'd4,
        LSU_LHU = 4'd5,
        LSU_SB  = 4'd6,
        LSU_SH  = 4'd7,
        LSU_SW  = 4'd8
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_store(lsu_op_e op);
        return op inside {LSU_SB, LSU_SH, LSU_SW};
    endfunction

    // Any op that touches memory; unknown encodings behave like NOP.
    function automatic logic is_mem_op(lsu_op_e op);
        return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW};
    endfunction

    function automatic logic is_half(lsu_op_e op);
        return op inside {LSU_LH, LSU_LHU, LSU_SH};
    endfunction

    function automatic logic is_word(lsu_op_e op);
        return op inside {LSU_LW, LSU_SW};
    endfunction

    function automatic logic misaligned(lsu_op_e op, logic [1:0] a);
        return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
    endfunction

    // Natural alignment of the low address bits for the access size.
    function automatic logic [1:0] align_lo(lsu_op_e op, logic [1:0] a);
        if (is_word(op)) return 2'b00;
        if (is_half(op)) return {a[1], 1'b0};
        return a;
    endfunction

    function automatic logic [3:0] byte_en(lsu_op_e op, logic [1:0] a);
        if (is_word(op)) return BE_WORD;
        if (is_half(op)) return BE_HALF << {a[1], 1'b0};
        return BE_BYTE << a;
    endfunction

    // Replicate store data across lanes so the byte enables pick the right copy.
    function automatic logic [31:0] store_data(lsu_op_e op, logic [31:0] d);
        if (is_word(op)) return d;
        if (is_half(op)) return {2{d[15:0]}};
        return {4{d[7:0]}};
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_ext.sv
// Load data lane selection and sign/zero extension (purely combinational).
module lsu_load_ext
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  lsu_op_e          op_i,
    input  logic [1:0]       a_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic [WIDTH-1:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to the load type.
    always_comb begin
        byte_sel = rdata_i[{a_i, 3'b000} +: 8];
        half_sel = rdata_i[{a_i[1], 4'b0000} +: 16];
        ext_o    = rdata_i;
        case (op_i)
            LSU_LB:  ext_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            LSU_LBU: ext_o = {{(WIDTH-8){1'b0}}, byte_sel};
            LSU_LH:  ext_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
            LSU_LHU: ext_o = {{(WIDTH-16){1'b0}}, half_sel};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: request/grant/response sequencer on the data-memory bus.
// Optional: LSU_MISALIGN_EXC_EN turns misaligned accesses into a flagged,
// bus-less completion; without it they are force-aligned and executed.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lsu_req_i,
    input  lsu_op_e          lsu_op_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             lsu_busy_o,
    output logic             lsu_done_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             misalign_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [3:0]       dmem_be_o,
    output logic [WIDTH-1:0] dmem_addr_o,
    output logic [WIDTH-1:0] dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [WIDTH-1:0] dmem_rdata_i
);

    lsu_state_e       state_q, state_d;
    lsu_op_e          op_q, op_d;
    logic [1:0]       off_q, off_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] ext_data;
    logic [1:0]       a_lo;
`ifdef LSU_MISALIGN_EXC_EN
    logic             misalign_q, misalign_d;
`endif

    assign a_lo = align_lo(lsu_op_i, addr_i[1:0]);

    lsu_load_ext #(
        .WIDTH (WIDTH)
    ) u_load_ext (
        .op_i    (op_q),
        .a_i     (off_q),
        .rdata_i (dmem_rdata_i),
        .ext_o   (ext_data)
    );

    // Next-state and registered-output logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_EXC_EN
        misalign_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    op_d = lsu_op_i;
                    if (!is_mem_op(lsu_op_i)) begin
                        state_d = DONE;
                    end
`ifdef LSU_MISALIGN_EXC_EN
                    else if (misaligned(lsu_op_i, addr_i[1:0])) begin
                        state_d    = DONE;
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                    end
`endif
                    else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = is_store(lsu_op_i);
                        be_d    = byte_en(lsu_op_i, a_lo);
                        addr_d  = {addr_i[WIDTH-1:2], 2'b00};
                        wdata_d = is_store(lsu_op_i) ? store_data(lsu_op_i, wdata_i) : '0;
                        off_d   = a_lo;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = we_q ? DONE : RESP;
                end
            end
            RESP: begin
                // rvalid only counts here, so one coincident with the grant is ignored.
                if (dmem_rvalid_i) begin
                    rdata_d = ext_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= LSU_NOP;
            off_q   <= 2'b00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    // Misalign flag lives only for the DONE cycle it was raised for.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign lsu_busy_o   = (state_q != IDLE);
    assign lsu_done_o   = (state_q == DONE);
    assign rdata_o      = rdata_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed scoreboard bench for lsu_ctrl with an inline data-memory responder.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    lsu_op_e     lsu_op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
    } sb_t;

    sb_t         sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .WIDTH (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .lsu_req_i     (lsu_req_i),
        .lsu_op_i      (lsu_op_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .lsu_busy_o    (lsu_busy_o),
        .lsu_done_o    (lsu_done_o),
        .rdata_o       (rdata_o),
        .misalign_o    (misalign_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/busy"}, lsu_busy_o, 0);
        check({tag, "/done"}, lsu_done_o, 0);
        check({tag, "/rdata"}, rdata_o, 0);
        check({tag, "/mis"}, misalign_o, 0);
        check({tag, "/req"}, dmem_req_o, 0);
        check({tag, "/we"}, dmem_we_o, 0);
        check({tag, "/be"}, dmem_be_o, 0);
        check({tag, "/addr"}, dmem_addr_o, 0);
        check({tag, "/wdata"}, dmem_wdata_o, 0);
    endtask

    // One transaction: issue, play the memory side, pop the scoreboard on done.
    task automatic run(input string tag, input lsu_op_e op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                       input logic [31:0] bus_rd, input logic exp_bus,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                       input logic e_mis);
        bit   is_ld, done_seen, granted, gnt_prev, req_prev;
        int   lat, req_rises, wait_cnt, rv_cnt;
        sb_t  ent;
        is_ld = op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
        if (!exp_bus) lat = 1;
        else if (!is_ld) lat = 2 + gnt_dly;
        else lat = 2 + gnt_dly + rv_dly;
        ent.tag = tag;
        ent.mis = e_mis;
        ent.lat = lat;
        if (e_mis) ent.rdata = 32'h0;
        else if (is_ld && exp_bus) ent.rdata = e_rdata;
        else ent.rdata = last_rdata;
        last_rdata = ent.rdata;
        sb_q.push_back(ent);

        @(negedge clk);
        lsu_req_i = 1'b1; lsu_op_i = op; addr_i = addr; wdata_i = wdata;
        @(negedge clk);
        lsu_req_i = 1'b0; lsu_op_i = LSU_NOP; addr_i = 32'h0; wdata_i = 32'h0;
        granted = 0; gnt_prev = 0; req_prev = 0; done_seen = 0;
        req_rises = 0; wait_cnt = 0; rv_cnt = 0;
        for (int c = 1; c <= 40 && !done_seen; c++) begin
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
            check({tag, "/busy"}, lsu_busy_o, 1);
            if (dmem_req_o && !req_prev) req_rises++;
            if (gnt_prev) check({tag, "/req_drop"}, dmem_req_o, 0);
            if (dmem_req_o) begin
                check({tag, "/addr"}, dmem_addr_o, e_addr);
                check({tag, "/be"}, dmem_be_o, e_be);
                check({tag, "/we"}, dmem_we_o, !is_ld);
                if (!is_ld) check({tag, "/wdata"}, dmem_wdata_o, e_wdata);
                if (wait_cnt == gnt_dly) begin
                    dmem_gnt_i = 1'b1;
                    granted = 1;
                    // Junk rvalid alongside the grant must be ignored.
                    if (is_ld) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0; end
                end
                wait_cnt++;
            end else if (granted && is_ld) begin
                rv_cnt++;
                if (rv_cnt == rv_dly) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = bus_rd; end
            end
            if (lsu_done_o) begin
                done_seen = 1;
                if (sb_q.size() == 0) begin
                    check({tag, "/sb_empty"}, 1, 0);
                end else begin
                    ent = sb_q.pop_front();
                    check({ent.tag, "/lat"}, c, ent.lat);
                    check({ent.tag, "/rdata"}, rdata_o, ent.rdata);
                    check({ent.tag, "/mis"}, misalign_o, ent.mis);
                end
            end
            req_prev = dmem_req_o;
            gnt_prev = dmem_gnt_i;
            @(negedge clk);
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        check({tag, "/done_seen"}, done_seen, 1);
        check({tag, "/req_count"}, req_rises, exp_bus ? 1 : 0);
        check({tag, "/post_done"}, lsu_done_o, 0);
        check({tag, "/post_busy"}, lsu_busy_o, 0);
        check({tag, "/post_req"}, dmem_req_o, 0);
        check({tag, "/post_rdata"}, rdata_o, last_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; lsu_req_i = 1'b0; lsu_op_i = LSU_NOP; addr_i = 32'h0; wdata_i = 32'h0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        //  tag       op       addr          wdata        g  r  bus_rd        bus addr          be       wdata         rdata         mis
        run("sw",   LSU_SW,  32'h0000_1004, 32'hDEAD_BEEF, 0, 1, 32'h0,        1, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0);
        run("sb",   LSU_SB,  32'h0000_2003, 32'h0000_00A5, 0, 1, 32'h0,        1, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0);
        run("sh",   LSU_SH,  32'h0000_3002, 32'h1234_BEEF, 1, 1, 32'h0,        1, 32'h0000_3000, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0);
        run("lb",   LSU_LB,  32'h0000_1001, 32'h0,         0, 1, 32'h1234_80FF, 1, 32'h0000_1000, 4'b0010, 32'h0,        32'hFFFF_FF80, 0);
        run("lbu",  LSU_LBU, 32'h0000_1001, 32'h0,         0, 1, 32'h1234_80FF, 1, 32'h0000_1000, 4'b0010, 32'h0,        32'h0000_0080, 0);
        run("lhu",  LSU_LHU, 32'h0000_1002, 32'h0,         0, 1, 32'h1234_80FF, 1, 32'h0000_1000, 4'b1100, 32'h0,        32'h0000_1234, 0);
        run("lh",   LSU_LH,  32'h0000_1000, 32'h0,         0, 2, 32'h0000_8001, 1, 32'h0000_1000, 4'b0011, 32'h0,        32'hFFFF_8001, 0);
        run("lw_slow", LSU_LW, 32'h0000_0100, 32'h0,       5, 3, 32'hCAFE_F00D, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'hCAFE_F00D, 0);
        run("sw_slow", LSU_SW, 32'h0000_0040, 32'h1122_3344, 5, 1, 32'h0,      1, 32'h0000_0040, 4'b1111, 32'h1122_3344, 32'h0,        0);
        run("nop",  LSU_NOP, 32'h0000_0123, 32'h0,         0, 1, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        32'h0,        0);
`ifdef LSU_MISALIGN_EXC_EN
        run("lw_mis", LSU_LW, 32'h0000_1002, 32'h0,        0, 1, 32'h55AA_55AA, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
        run("sh_mis", LSU_SH, 32'h0000_1001, 32'h0000_ABCD, 0, 1, 32'h0,       0, 32'h0,         4'b0000, 32'h0,        32'h0,        1);
`else
        run("lw_mis", LSU_LW, 32'h0000_1002, 32'h0,        0, 1, 32'h55AA_55AA, 1, 32'h0000_1000, 4'b1111, 32'h0,       32'h55AA_55AA, 0);
        run("sh_mis", LSU_SH, 32'h0000_1001, 32'h0000_ABCD, 0, 1, 32'h0,       1, 32'h0000_1000, 4'b0011, 32'hABCD_ABCD, 32'h0,       0);
`endif

        // Reset while waiting in RESP; a later rvalid must be ignored.
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_op_i = LSU_LW; addr_i = 32'h0000_1000;
        @(negedge clk);
        lsu_req_i = 1'b0; lsu_op_i = LSU_NOP; addr_i = 32'h0;
        check("rst/req", dmem_req_o, 1);
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        check("rst/in_resp_busy", lsu_busy_o, 1);
        check("rst/in_resp_req", dmem_req_o, 0);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_all_zero("rst/after");
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
            check_all_zero("rst/late_rvalid");
        end
        last_rdata = 32'h0;

        run("lbu_recover", LSU_LBU, 32'h0000_1003, 32'h0, 0, 1, 32'hAB00_0000, 1, 32'h0000_1000,
            4'b1000, 32'h0, 32'h0000_00AB, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a request/grant/response transaction on the data-memory bus and returns aligned, sign- or zero-extended load data to writeback.
- Stalls the core through lsu_busy_o while a transaction is outstanding.

Parameters:
- WIDTH, 32, datapath/address width. Only 32 is supported.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- lsu_req_i  in  1  start access; sampled only in IDLE.
- lsu_op_i  in  lsu_op_e  LSU_LB/LH/LW/LBU/LHU/SB/SH/SW/LSU_NOP.
- addr_i  in  WIDTH  effective address, driven from the ALU's alu_data_o.
- wdata_i  in  WIDTH  store data (rs2).
- lsu_busy_o  out  1  state != IDLE.
- lsu_done_o  out  1  one-cycle completion pulse.
- rdata_o  out  WIDTH  extended load data; valid while lsu_done_o=1.
- misalign_o  out  1  misaligned access flag, qualified by lsu_done_o.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = store.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  WIDTH  word address, bits [1:0] = 0.
- dmem_wdata_o  out  WIDTH  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  WIDTH  read data.

Behaviour:
- Single clock clk_i; synchronous active-high reset rst_i.
- Reset: state=IDLE. Every output is 0: dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, lsu_busy_o, lsu_done_o, rdata_o, misalign_o.
- Reset mid-transaction: dmem_req_o drops on the next edge. Any later rvalid is ignored, because rvalid is sampled only in RESP.
- FSM states: IDLE, REQ, RESP, DONE. All bus outputs are registered.
- IDLE, with lsu_req_i=1: latch op, addr and wdata.
  - NOP goes to DONE.
  - Misaligned access with the macro enabled goes to DONE.
  - Otherwise go to REQ.
  - lsu_req_i is ignored in every other state.
- REQ: dmem_req_o=1. Address, be, we and wdata stay stable until dmem_gnt_i=1.
  - On grant, a store goes to DONE and a load goes to RESP.
  - dmem_req_o deasserts the cycle after the grant.
- RESP: wait for dmem_rvalid_i. An rvalid in the same cycle as the grant is not accepted; the earliest accepted rvalid is the cycle after the grant. On rvalid, register the extended data into rdata_o and go to DONE.
- DONE: lsu_done_o=1 for exactly one cycle, then IDLE. rdata_o holds its value until the next load completes.
- Minimum latency, counting the request cycle as cycle 0 and assuming grant in the first REQ cycle:
  - store: done on cycle 2.
  - load with next-cycle rvalid: done on cycle 3.
  - NOP or misaligned access: done on cycle 1.
- Store byte enables and data:
  - SB: be = 4'b0001 << a[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << {a[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
  - dmem_addr_o = {a[31:2],2'b00}.
- Loads:
  - Select byte a[1:0] (LB/LBU) or half a[1] (LH/LHU) from dmem_rdata_i.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through.
  - Load byte enables follow the same patterns as stores; dmem_we_o=0.
- Misaligned access means: H ops with a[0]=1, or W ops with a[1:0]!=0.

Optional Feature:
- Macro LSU_MISALIGN_EXC_EN.
- Defined: a misaligned access issues no bus transaction and goes IDLE→DONE. In the DONE cycle misalign_o=1 and rdata_o=0.
- Undefined: misalign_o is tied to 0. The address low bits are forced to natural alignment (H clears a[0], W clears a[1:0]) and the transaction proceeds normally.

Decomposition:
- Add to mypkg:
  - lsu_op_e: 4-bit enum, with LSU_NOP as the default.
  - lsu_state_e: IDLE/REQ/RESP/DONE.
  - Constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
- One combinational sub-module, lsu_load_ext: inputs op, a[1:0] and rdata; output is the extended WIDTH word.

Test Plan:
- SW, addr=0x0000_1004, wdata=0xDEAD_BEEF, grant on the first REQ cycle → dmem_addr_o=0x1004, be=1111, we=1. lsu_done_o at cycle 2; busy on cycles 1–2.
- SB, addr=0x0000_2003, wdata=0x0000_00A5 → be=1000, dmem_wdata_o=0xA5A5_A5A5, dmem_addr_o=0x2000.
- LB, addr=0x1001, dmem_rdata_i=0x1234_80FF, rvalid one cycle after the grant → rdata_o=0xFFFF_FF80. LBU with the same stimulus → 0x0000_0080. LHU at addr=0x1002 → 0x0000_1234.
- Grant held low for 5 cycles, then rvalid 3 cycles later → REQ outputs stay stable throughout, single done pulse, no duplicate request.
- LW, addr=0x1002:
  - With LSU_MISALIGN_EXC_EN: no dmem_req_o; done at cycle 1 with misalign_o=1, rdata_o=0.
  - Without it: dmem_addr_o=0x1000, be=1111.
- rst_i asserted while in RESP, rvalid arrives afterwards → state IDLE, all outputs 0, no done pulse.
